// File: rtl/exp_led_pkg.sv
// Shared widths, FSM encodings and the level-to-duty mapping for the exp_led_pwm blocks.
package exp_led_pkg;

  localparam int unsigned LVL_W  = 8;
  localparam int unsigned DUTY_W = 16;
  localparam int unsigned EXP_W  = 4;
  localparam int unsigned MANT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // 4.4 pseudo-float level to exponential duty. e=0 keeps only the top mantissa bit so the
  // curve stays monotonic into e=1 (f(0x0F)=1, f(0x10)=2).
  function automatic logic [DUTY_W-1:0] exp_map_f(input logic [LVL_W-1:0] lvl,
                                                   input bit full_ones);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    logic [DUTY_W-1:0] res;
    e = lvl[LVL_W-1:MANT_W];
    m = lvl[MANT_W-1:0];
    if (full_ones && (lvl == 8'hFF)) begin
      res = 16'hFFFF;
    end else if (e == 4'd0) begin
      res = {15'b0, m[3]};
    end else begin
      res = {1'b1, m, 11'b0} >> (4'd15 - e);
    end
    return res;
  endfunction

endpackage

// File: rtl/exp_duty_map.sv
// Maps an 8-bit linear brightness level onto a 16-bit exponential PWM duty word.
// Default build shifts one bit per cycle to stay small; FAST selects a one-cycle barrel shift.
module exp_duty_map
  import exp_led_pkg::*;
#(
  parameter bit FAST      = 1'b0,
  parameter bit FULL_ONES = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [LVL_W-1:0]  lvl_in,
  input  logic              lvl_valid,
  output logic              lvl_ready,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  input  logic              duty_ready,
  output logic              busy
);

  state_e            state_q;
  logic [DUTY_W-1:0] acc_q;
  logic [3:0]        cnt_q;
  logic              special;
  logic [DUTY_W-1:0] direct;

  // Levels whose result needs no shifting are loaded finished, with a zero shift count.
  always_comb begin
    direct  = exp_map_f(lvl_in, FULL_ONES);
    special = (lvl_in[LVL_W-1:MANT_W] == 4'd0) || (FULL_ONES && (lvl_in == 8'hFF));
  end

  // Handshake flags follow the state directly.
  always_comb begin
    lvl_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
  end

  // Conversion FSM with registered duty outputs; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      duty_out   <= '0;
      duty_valid <= 1'b0;
    end else if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (lvl_valid) begin
            if (FAST) begin
              duty_out   <= direct;
              duty_valid <= 1'b1;
              state_q    <= ST_HOLD;
            end else begin
              if (special) begin
                acc_q <= direct;
                cnt_q <= 4'd0;
              end else begin
                acc_q <= {1'b1, lvl_in[MANT_W-1:0], 11'b0};
                // Exponent is at least 1 here, so the count tops out at 14 and never wraps.
                cnt_q <= 4'd15 - lvl_in[LVL_W-1:MANT_W];
              end
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (cnt_q == 4'd0) begin
            duty_out   <= acc_q;
            duty_valid <= 1'b1;
            state_q    <= ST_HOLD;
          end else begin
            acc_q <= acc_q >> 1;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (duty_ready) begin
            duty_valid <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          duty_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
